parity_rx_framer: RTL and testbench

Serial frame receiver for the parity link, directly downstream of the parity serializer. It consumes the one-bit-per-clock serial stream and finds frames by their start bit. It shifts the data bits into a byte, checks the parity and stop bits, and presents the result on a valid/ready output register with error and overrun flags. It runs in the same clock domain as the transmitter; the link is bit-synchronous, with no oversampling.

---
 rtl/parity_link_pkg.sv | 22 ++
 rtl/parity_rx_framer_if.sv | 24 ++
 rtl/rx_hold_reg.sv | 69 ++++++
 rtl/parity_rx_framer.sv | 128 ++++++++++++
 tb/tb_parity_rx_framer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/parity_link_pkg.sv
// Shared definitions for the parity link: receiver FSM states, frame-level
// line constants and the parity reduction used by both link ends.
package parity_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_HUNT
  } rx_state_e;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;
  localparam logic LINE_IDLE = 1'b0;

  // Callers zero-extend their word; extra zeros do not change the XOR.
  function automatic logic reduce_parity(input logic [31:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/parity_rx_framer_if.sv
// Serial-in / word-out bundle of the parity receiver. The master modport is
// the framer itself, the slave modport is the line driver plus word consumer.
interface parity_rx_framer_if #(
  parameter int DATA_W = 8
);
  logic              SDin;
  logic              Dready;
  logic [DATA_W-1:0] Dout;
  logic              Dvalid;
  logic              Par_error;
  logic              Frame_error;
  logic              Overrun;
  logic              Busy;

  modport master (
    input  SDin, Dready,
    output Dout, Dvalid, Par_error, Frame_error, Overrun, Busy
  );

  modport slave (
    output SDin, Dready,
    input  Dout, Dvalid, Par_error, Frame_error, Overrun, Busy
  );
endinterface

// File: rtl/rx_hold_reg.sv
// Valid/ready output register for received words with a sticky overrun flag
// raised whenever a completed frame has to be dropped.
module rx_hold_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_par_err,
  input  logic              i_frm_err,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_par_err,
  output logic              o_frm_err,
  output logic              o_overrun
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_par_err;
  logic              r_frm_err;
  logic              r_overrun;

  logic w_accept;
  logic w_take;
  logic w_drop;

  assign w_accept = r_valid & i_ready;
  assign w_take   = i_load & (~r_valid | i_ready);
  assign w_drop   = i_load & r_valid & ~i_ready;

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_take) begin
        r_data    <= i_data;
        r_par_err <= i_par_err;
        r_frm_err <= i_frm_err;
        r_valid   <= 1'b1;
      end else if (w_accept) begin
        r_valid   <= 1'b0;
        r_par_err <= 1'b0;
        r_frm_err <= 1'b0;
      end

      // A drop needs Dready low, so it can never coincide with an accept.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (w_accept) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_par_err = r_par_err;
  assign o_frm_err = r_frm_err;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/parity_rx_framer.sv
// Bit-synchronous frame receiver: start bit, DATA_W data bits MSB first,
// parity bit, stop bit. Completed frames go to the rx_hold_reg output stage.
module parity_rx_framer
  import parity_link_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PARITY_ODD = 0
) (
  input logic                Clk,
  input logic                Rst_n,
  parity_rx_framer_if.master bus
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  rx_state_e r_state;
  rx_state_e w_next;

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_bit;
  logic              r_busy;

  logic w_cnt_clr;
  logic w_shift_en;
  logic w_par_latch;
  logic w_frame_done;
  logic w_last_bit;
  logic w_par_err;
  logic w_frm_err;

  logic [DATA_W-1:0] w_dout;
  logic              w_dvalid;
  logic              w_par_err_q;
  logic              w_frm_err_q;
  logic              w_overrun;

  assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: defaulting every always_comb output first keeps latches from being inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (bus.SDin == START_BIT) w_next = ST_DATA;
      ST_DATA:   if (w_last_bit) w_next = ST_PARITY;
      ST_PARITY: w_next = ST_STOP;
      ST_STOP:   w_next = (bus.SDin == STOP_BIT) ? ST_IDLE : ST_HUNT;
      ST_HUNT:   if (bus.SDin == LINE_IDLE) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clr    = 1'b0;
    w_shift_en   = 1'b0;
    w_par_latch  = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE:   w_cnt_clr    = (bus.SDin == START_BIT);
      ST_DATA:   w_shift_en   = 1'b1;
      ST_PARITY: w_par_latch  = 1'b1;
      ST_STOP:   w_frame_done = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_shift_en) begin
        r_shift <= {r_shift[DATA_W-2:0], bus.SDin};
      end

      if (w_par_latch) begin
        r_par_bit <= bus.SDin;
      end

      // Busy mirrors the state being entered so it stays a plain flop output.
      r_busy <= (w_next == ST_DATA) || (w_next == ST_PARITY) || (w_next == ST_STOP);
    end
  end

  assign w_par_err = reduce_parity(32'(r_shift)) ^ r_par_bit ^ PARITY_ODD[0];
  assign w_frm_err = (bus.SDin != STOP_BIT);

  rx_hold_reg #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .i_load    (w_frame_done),
    .i_data    (r_shift),
    .i_par_err (w_par_err),
    .i_frm_err (w_frm_err),
    .i_ready   (bus.Dready),
    .o_data    (w_dout),
    .o_valid   (w_dvalid),
    .o_par_err (w_par_err_q),
    .o_frm_err (w_frm_err_q),
    .o_overrun (w_overrun)
  );

  assign bus.Dout        = w_dout;
  assign bus.Dvalid      = w_dvalid;
  assign bus.Par_error   = w_par_err_q;
  assign bus.Frame_error = w_frm_err_q;
  assign bus.Overrun     = w_overrun;
  assign bus.Busy        = r_busy;

endmodule

// File: tb/tb_parity_rx_framer.sv
// Drives one serial stream into an even- and an odd-parity receiver and checks
// every cycle against a stream parser plus hold-register model.
module tb_parity_rx_framer;

  localparam int DW = 8;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  parity_rx_framer_if #(.DATA_W(DW)) bus_e ();
  parity_rx_framer_if #(.DATA_W(DW)) bus_o ();

  parity_rx_framer #(.DATA_W(DW), .PARITY_ODD(0)) u_even (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus_e)
  );

  parity_rx_framer #(.DATA_W(DW), .PARITY_ODD(1)) u_odd (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus_o)
  );

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic          pe;
    logic          fe;
    logic          ov;
    logic          busy;
  } exp_t;

  bit   bit_q[$];
  bit   rdy_q[$];
  bit   rst_q[$];
  exp_t exp_e[$];
  exp_t exp_o[$];

  int rdy_prob    = 100;
  int rst_permill = 0;
  int checks      = 0;
  int failures    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic push_bit(input bit b, input bit r = 1'b0);
    bit_q.push_back(b);
    rdy_q.push_back($urandom_range(99) < rdy_prob);
    rst_q.push_back(r || ($urandom_range(999) < rst_permill));
  endtask

  task automatic push_frame(input logic [DW-1:0] data, input bit flip, input bit stop);
    push_bit(1'b1);
    for (int k = DW - 1; k >= 0; k--) push_bit(data[k]);
    push_bit((^data) ^ flip);
    push_bit(stop);
  endtask

  task automatic push_idle(input int n);
    for (int k = 0; k < n; k++) push_bit(1'b0);
  endtask

  // Frame parser over the whole stream, then the output-register rules per edge.
  task automatic build_model(input bit odd);
    int            n;
    int            t;
    int            t0;
    int            ab;
    int            e;
    bit            dv[];
    bit            dpe[];
    bit            dfe[];
    bit            bz[];
    logic [DW-1:0] dd[];
    logic [DW-1:0] data;
    exp_t          cur;
    exp_t          q[$];

    n = bit_q.size();
    dv = new[n]; dpe = new[n]; dfe = new[n]; bz = new[n]; dd = new[n];
    t = 0;
    while (t < n) begin
      if (rst_q[t] || !bit_q[t]) begin
        t++;
        continue;
      end
      t0 = t;
      ab = -1;
      for (int k = 1; k <= DW + 2; k++) begin
        if (t0 + k >= n) begin ab = n; break; end
        if (rst_q[t0 + k]) begin ab = t0 + k; break; end
      end
      if (ab >= 0) begin
        for (int j = t0; j < ab; j++) bz[j] = 1'b1;
        t = ab;
        continue;
      end
      for (int j = t0; j <= t0 + DW + 1; j++) bz[j] = 1'b1;
      data = '0;
      for (int k = 1; k <= DW; k++) data = {data[DW-2:0], bit_q[t0 + k]};
      e = t0 + DW + 2;
      dv[e]  = 1'b1;
      dd[e]  = data;
      dpe[e] = (^data) ^ bit_q[t0 + DW + 1] ^ odd;
      dfe[e] = bit_q[e];
      t = e + 1;
      if (bit_q[e]) begin
        while (t < n && !rst_q[t] && bit_q[t]) t++;
        if (t < n && !rst_q[t]) t++;
      end
    end

    cur = '0;
    for (int i = 0; i < n; i++) begin
      if (rst_q[i]) begin
        cur = '0;
      end else begin
        if (dv[i] && cur.v && !rdy_q[i]) begin
          cur.ov = 1'b1;
        end else if (dv[i]) begin
          if (cur.v) cur.ov = 1'b0;
          cur.v = 1'b1; cur.d = dd[i]; cur.pe = dpe[i]; cur.fe = dfe[i];
        end else if (cur.v && rdy_q[i]) begin
          cur.v = 1'b0; cur.pe = 1'b0; cur.fe = 1'b0; cur.ov = 1'b0;
        end
        cur.busy = bz[i];
      end
      if (rst_q[i]) cur.busy = 1'b0;
      q.push_back(cur);
    end
    if (odd) exp_o = q; else exp_e = q;
  endtask

  task automatic cmp(input string who, input int t, input exp_t w, input logic v,
                     input logic [DW-1:0] d, input logic pe, input logic fe,
                     input logic ov, input logic busy);
    check($sformatf("%s c%0d Dvalid", who, t), 32'(v), 32'(w.v));
    check($sformatf("%s c%0d Dout", who, t), 32'(d), 32'(w.d));
    check($sformatf("%s c%0d Par_error", who, t), 32'(pe), 32'(w.pe));
    check($sformatf("%s c%0d Frame_error", who, t), 32'(fe), 32'(w.fe));
    check($sformatf("%s c%0d Overrun", who, t), 32'(ov), 32'(w.ov));
    check($sformatf("%s c%0d Busy", who, t), 32'(busy), 32'(w.busy));
  endtask

  initial begin
    bus_e.SDin = 1'b0; bus_e.Dready = 1'b0;
    bus_o.SDin = 1'b0; bus_o.Dready = 1'b0;

    push_bit(1'b0, 1'b1);
    push_bit(1'b0, 1'b1);

    // Clean 0xA5, then 0xA5 with its parity bit forced to 1.
    push_frame(8'hA5, 1'b0, 1'b0);
    push_idle(3);
    push_frame(8'hA5, 1'b1, 1'b0);
    push_idle(3);

    // Bad stop bit, a run of ones that must not start a frame, then 0x81.
    push_frame(8'h3C, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) push_bit(1'b1);
    push_bit(1'b0);
    push_frame(8'h81, 1'b0, 1'b0);
    push_idle(3);

    // Back-to-back frames with the consumer stalled, then released.
    rdy_prob = 0;
    push_frame(8'h11, 1'b0, 1'b0);
    push_frame(8'h22, 1'b0, 1'b0);
    push_idle(4);
    rdy_prob = 100;
    push_idle(1);
    rdy_prob = 0;
    push_idle(2);
    rdy_prob = 100;
    push_idle(2);

    // Ready arrives on the very edge the second frame completes.
    rdy_prob = 0;
    push_frame(8'h11, 1'b0, 1'b0);
    push_frame(8'h22, 1'b0, 1'b0);
    rdy_q[rdy_q.size() - 1] = 1'b1;
    push_idle(2);
    rdy_prob = 100;
    push_idle(2);

    // Reset after data bit 4 abandons the frame; 0xFF follows.
    push_bit(1'b1);
    push_bit(1'b1); push_bit(1'b0); push_bit(1'b1); push_bit(1'b1);
    push_bit(1'b1, 1'b1);
    push_idle(2);
    push_frame(8'hFF, 1'b0, 1'b0);
    push_idle(3);

    // Randomized traffic: gaps, errors, hunts, raw noise, stalls, resets.
    rst_permill = 3;
    for (int f = 0; f < 250; f++) begin
      bit stop;
      rdy_prob = $urandom_range(20, 100);
      push_idle($urandom_range(0, 3));
      stop = ($urandom_range(9) == 0);
      push_frame(DW'($urandom), ($urandom_range(9) == 0), stop);
      if (stop) begin
        for (int k = $urandom_range(0, 4); k > 0; k--) push_bit(1'b1);
      end
      if ($urandom_range(19) == 0) begin
        for (int k = 0; k < 12; k++) push_bit(1'($urandom));
      end
    end
    rst_permill = 0;
    rdy_prob = 100;
    push_idle(16);

    build_model(1'b0);
    build_model(1'b1);

    for (int t = 0; t < bit_q.size(); t++) begin
      Rst_n        = !rst_q[t];
      bus_e.SDin   = bit_q[t];
      bus_o.SDin   = bit_q[t];
      bus_e.Dready = rdy_q[t];
      bus_o.Dready = rdy_q[t];
      @(posedge Clk);
      #1;
      cmp("even", t, exp_e[t], bus_e.Dvalid, bus_e.Dout, bus_e.Par_error,
          bus_e.Frame_error, bus_e.Overrun, bus_e.Busy);
      cmp("odd", t, exp_o[t], bus_o.Dvalid, bus_o.Dout, bus_o.Par_error,
          bus_o.Frame_error, bus_o.Overrun, bus_o.Busy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
